// File: rtl/trace_change_monitor_if.sv
// Event stream carried from the change monitor to its consumer.
// The monitor drives the head record and valid; the consumer drives ready.
interface trace_change_monitor_if #(
  parameter int CHANNELS = 10,
  parameter int WIDTH    = 1,
  parameter int CNTW     = 8
);
  localparam int CIW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic            out_valid;
  logic            out_ready;
  logic [CIW-1:0]  out_chan;
  logic [WIDTH-1:0] out_value;
  logic [CNTW-1:0] out_seq;

  modport master (
    output out_valid,
    output out_chan,
    output out_value,
    output out_seq,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_chan,
    input  out_value,
    input  out_seq,
    output out_ready
  );
endinterface

// File: rtl/trace_change_monitor.sv
// Multi-channel value-change monitor. Detects changes on CHANNELS buses,
// holds one pending value per channel, arbitrates round-robin into an
// in-order event FIFO and counts every overwritten (lost) pending value.
module trace_change_monitor #(
  parameter int CHANNELS = 10,
  parameter int WIDTH    = 1,
  parameter int DEPTH    = 4,
  parameter int CNTW     = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] ch_in,
  trace_change_monitor_if.master    out_if,
  output logic [CNTW-1:0]           coalesce_count,
  output logic                      busy
);
  localparam int CIW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int AW  = $clog2(DEPTH);
  localparam int EW  = CIW + WIDTH + CNTW;

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t                    state;
  logic [CHANNELS*WIDTH-1:0] prev;
  logic [WIDTH-1:0]          pval [CHANNELS];
  logic [CHANNELS-1:0]       pend;
  logic [CIW-1:0]            rr_ptr;
  logic [CNTW-1:0]           seq;
  logic [EW-1:0]             mem [DEPTH];
  logic [AW-1:0]             wr_ptr;
  logic [AW-1:0]             rd_ptr;
  logic [AW:0]               count;

  logic [CHANNELS-1:0]       chg;
  logic [CHANNELS-1:0]       coal;
  logic [CHANNELS-1:0]       sel_oh;
  logic [CHANNELS-1:0]       gnt_oh;
  logic [CIW-1:0]            gnt_ch;
  logic                      gnt_vld;
  logic                      full;
  logic                      pop;
  logic [EW-1:0]             head;

  // Adds n to a counter, sticking at the all-ones maximum.
  function automatic logic [CNTW-1:0] sat_add(input logic [CNTW-1:0] a, input int n);
    longint s;
    longint mx;
    s  = longint'(a) + longint'(n);
    mx = (longint'(1) << CNTW) - 1;
    if (s > mx) s = mx;
    return CNTW'(s);
  endfunction

  assign full = (count == (AW+1)'(DEPTH));
  assign pop  = out_if.out_valid && out_if.out_ready;

  // Change detection; suppressed on the INIT edge so the first sample only primes prev.
  always_comb begin
    chg = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      chg[c] = (state == S_RUN) && (ch_in[c*WIDTH +: WIDTH] != prev[c*WIDTH +: WIDTH]);
    end
  end

  // Round-robin search from rr_ptr; a grant needs a free slot by registered count.
  always_comb begin
    int             s;
    logic [CIW-1:0] idx;
    logic           found;
    s      = 0;
    idx    = '0;
    found  = 1'b0;
    gnt_ch = '0;
    sel_oh = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      s = int'(rr_ptr) + i;
      if (s >= CHANNELS) s = s - CHANNELS;
      idx = CIW'(s);
      if (!found && pend[idx]) begin
        found       = 1'b1;
        gnt_ch      = idx;
        sel_oh[idx] = 1'b1;
      end
    end
    gnt_vld = found && !full && (state == S_RUN);
    gnt_oh  = gnt_vld ? sel_oh : '0;
  end

  // A change on an already-pending, ungranted channel loses the older pending value.
  assign coal = chg & pend & ~gnt_oh;

  // Control state: INIT/RUN, pending flags, arbiter pointer, counters, FIFO pointers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_INIT;
      pend           <= '0;
      rr_ptr         <= '0;
      seq            <= '0;
      coalesce_count <= '0;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
    end else begin
      state          <= S_RUN;
      pend           <= (pend & ~gnt_oh) | chg;
      coalesce_count <= sat_add(coalesce_count, $countones(coal));
      if (gnt_vld) begin
        wr_ptr <= wr_ptr + 1'b1;
        seq    <= seq + 1'b1;
        rr_ptr <= (gnt_ch == CIW'(CHANNELS-1)) ? '0 : gnt_ch + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({gnt_vld, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Data path: last sample, newest pending value per channel, FIFO storage.
  always_ff @(posedge clk) begin
    prev <= ch_in;
    for (int c = 0; c < CHANNELS; c++) begin
      if (chg[c]) pval[c] <= ch_in[c*WIDTH +: WIDTH];
    end
    if (gnt_vld) mem[wr_ptr] <= {gnt_ch, pval[gnt_ch], seq};
  end

  assign head             = mem[rd_ptr];
  assign out_if.out_valid = (count != '0);
  assign out_if.out_chan  = out_if.out_valid ? head[EW-1 -: CIW]    : '0;
  assign out_if.out_value = out_if.out_valid ? head[CNTW +: WIDTH]  : '0;
  assign out_if.out_seq   = out_if.out_valid ? head[CNTW-1:0]       : '0;
  assign busy             = out_if.out_valid || (|pend);

endmodule

// File: tb/tb_trace_change_monitor.sv
// Bench for trace_change_monitor: directed scenarios followed by random
// channel activity and random back-pressure, compared every cycle against
// an event-level reference model.
module tb_trace_change_monitor;
  localparam int CH  = 10;
  localparam int W   = 1;
  localparam int D   = 4;
  localparam int CW  = 8;
  localparam int CMAX = (1 << CW) - 1;

  typedef struct {
    int ch;
    int val;
    int seq;
  } ev_t;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b1;
  logic [CH*W-1:0] ch_in = '0;
  logic [CW-1:0] coal;
  logic          busy;

  trace_change_monitor_if #(.CHANNELS(CH), .WIDTH(W), .CNTW(CW)) ifc ();

  trace_change_monitor #(.CHANNELS(CH), .WIDTH(W), .DEPTH(D), .CNTW(CW)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ch_in          (ch_in),
    .out_if         (ifc.master),
    .coalesce_count (coal),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  bit  m_init;
  int  m_prev [CH];
  bit  m_pend [CH];
  int  m_pval [CH];
  int  m_rr;
  int  m_seq;
  int  m_coal;
  ev_t m_q [$];
  ev_t dut_log [$];

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    m_init = 1'b1;
    m_rr   = 0;
    m_seq  = 0;
    m_coal = 0;
    m_q.delete();
    for (int c = 0; c < CH; c++) begin
      m_pend[c] = 1'b0;
      m_pval[c] = 0;
      m_prev[c] = 0;
    end
  endfunction

  // One rising edge of the monitor as described at event level.
  function automatic void model_edge(input logic [CH*W-1:0] in, input bit rdy);
    int cur [CH];
    int g;
    bit full;
    for (int c = 0; c < CH; c++) cur[c] = int'(in[c*W +: W]);
    if (m_init) begin
      m_prev = cur;
      m_init = 1'b0;
      return;
    end
    full = (m_q.size() >= D);
    if (m_q.size() > 0 && rdy) void'(m_q.pop_front());
    g = -1;
    if (!full) begin
      for (int i = 0; i < CH; i++) begin
        int c;
        c = (m_rr + i) % CH;
        if (m_pend[c]) begin
          g = c;
          break;
        end
      end
    end
    if (g >= 0) begin
      m_q.push_back('{g, m_pval[g], m_seq});
      m_seq     = (m_seq + 1) % (1 << CW);
      m_rr      = (g + 1) % CH;
      m_pend[g] = 1'b0;
    end
    for (int c = 0; c < CH; c++) begin
      if (cur[c] != m_prev[c]) begin
        if (m_pend[c]) m_coal = (m_coal < CMAX) ? m_coal + 1 : CMAX;
        m_pend[c] = 1'b1;
        m_pval[c] = cur[c];
      end
    end
    m_prev = cur;
  endfunction

  function automatic bit model_busy();
    bit b;
    b = (m_q.size() > 0);
    for (int c = 0; c < CH; c++) b = b | m_pend[c];
    return b;
  endfunction

  task automatic compare_all();
    chk("valid", longint'(ifc.out_valid), longint'(m_q.size() > 0));
    if (m_q.size() > 0) begin
      chk("chan",  longint'(ifc.out_chan),  longint'(m_q[0].ch));
      chk("value", longint'(ifc.out_value), longint'(m_q[0].val));
      chk("seq",   longint'(ifc.out_seq),   longint'(m_q[0].seq));
    end
    chk("coalesce", longint'(coal), longint'(m_coal));
    chk("busy", longint'(busy), longint'(model_busy()));
  endtask

  // Advance one clock: log any DUT pop, update the model, compare after the edge.
  task automatic step();
    logic [CH*W-1:0] in_s;
    bit rdy_s;
    in_s  = ch_in;
    rdy_s = ifc.out_ready;
    if (rst_n && ifc.out_valid && ifc.out_ready)
      dut_log.push_back('{int'(ifc.out_chan), int'(ifc.out_value), int'(ifc.out_seq)});
    @(posedge clk);
    if (rst_n) model_edge(in_s, rdy_s);
    #1;
    compare_all();
  endtask

  task automatic do_reset(input logic [CH*W-1:0] v);
    rst_n = 1'b0;
    ch_in = v;
    #1;
    chk("rst_valid", longint'(ifc.out_valid), 0);
    chk("rst_chan",  longint'(ifc.out_chan),  0);
    chk("rst_value", longint'(ifc.out_value), 0);
    chk("rst_seq",   longint'(ifc.out_seq),   0);
    chk("rst_coal",  longint'(coal), 0);
    chk("rst_busy",  longint'(busy), 0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [CH*W-1:0] m;
    int c0;
    ifc.out_ready = 1'b0;
    #1;

    // Startup suppression: all ones present at reset release
    do_reset('1);
    step();
    chk("init_valid", longint'(ifc.out_valid), 0);
    chk("init_busy",  longint'(busy), 0);
    step();
    step();
    chk("init_valid2", longint'(ifc.out_valid), 0);
    chk("init_busy2",  longint'(busy), 0);

    // Single change on channel 3
    do_reset('0);
    step();
    ifc.out_ready = 1'b1;
    ch_in[3] = 1'b1;
    step();
    chk("single_t_valid", longint'(ifc.out_valid), 0);
    chk("single_t_busy",  longint'(busy), 1);
    step();
    chk("single_valid", longint'(ifc.out_valid), 1);
    chk("single_chan",  longint'(ifc.out_chan), 3);
    chk("single_value", longint'(ifc.out_value), 1);
    chk("single_seq",   longint'(ifc.out_seq), 0);
    step();
    chk("single_popped", longint'(ifc.out_valid), 0);
    chk("single_idle",   longint'(busy), 0);

    // All channels change at once
    do_reset('0);
    step();
    ch_in = '1;
    dut_log.delete();
    step();
    for (int i = 0; i < CH; i++) begin
      step();
      chk("sim_valid", longint'(ifc.out_valid), 1);
      chk("sim_chan",  longint'(ifc.out_chan), longint'(i));
      chk("sim_seq",   longint'(ifc.out_seq),  longint'(i));
    end
    step();
    chk("sim_done",  longint'(ifc.out_valid), 0);
    chk("sim_count", longint'(dut_log.size()), 10);
    chk("sim_coal",  longint'(coal), 0);

    // Backpressure and coalesce
    do_reset('0);
    step();
    ifc.out_ready = 1'b0;
    ch_in = 10'h01F;
    step();
    for (int i = 0; i < 4; i++) step();
    ch_in[4] = 1'b0;
    step();
    ch_in[4] = 1'b1;
    step();
    chk("bp_coal",  longint'(coal), 2);
    chk("bp_head",  longint'(ifc.out_chan), 0);
    chk("bp_busy",  longint'(busy), 1);
    dut_log.delete();
    ifc.out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (dut_log.size() >= 5) break;
      step();
    end
    chk("bp_count", longint'(dut_log.size()), 5);
    if (dut_log.size() >= 5) begin
      for (int k = 0; k < 4; k++) chk("bp_order", longint'(dut_log[k].ch), longint'(k));
      chk("bp_ch4",     longint'(dut_log[4].ch),  4);
      chk("bp_ch4_val", longint'(dut_log[4].val), 1);
      chk("bp_ch4_seq", longint'(dut_log[4].seq), 4);
    end

    // Grant/change race on channel 2
    c0 = int'(coal);
    dut_log.delete();
    ch_in[2] = 1'b0;
    step();
    ch_in[2] = 1'b1;
    step();
    for (int i = 0; i < 3; i++) step();
    chk("race_count", longint'(dut_log.size()), 2);
    if (dut_log.size() >= 2) begin
      chk("race_ch_a",  longint'(dut_log[0].ch),  2);
      chk("race_val_a", longint'(dut_log[0].val), 0);
      chk("race_seq_a", longint'(dut_log[0].seq), 5);
      chk("race_ch_b",  longint'(dut_log[1].ch),  2);
      chk("race_val_b", longint'(dut_log[1].val), 1);
      chk("race_seq_b", longint'(dut_log[1].seq), 6);
    end
    chk("race_coal", longint'(coal), longint'(c0));

    // Reset with three events queued
    ifc.out_ready = 1'b0;
    ch_in = ch_in ^ 10'h007;
    step();
    for (int i = 0; i < 3; i++) step();
    chk("mid_queued", longint'(ifc.out_valid), 1);
    do_reset(ch_in ^ 10'h200);
    step();
    chk("mid_init_valid", longint'(ifc.out_valid), 0);
    chk("mid_init_busy",  longint'(busy), 0);
    ifc.out_ready = 1'b1;
    ch_in[5] = ~ch_in[5];
    step();
    step();
    chk("mid_valid", longint'(ifc.out_valid), 1);
    chk("mid_chan",  longint'(ifc.out_chan), 5);
    chk("mid_seq",   longint'(ifc.out_seq), 0);

    // Random activity with random back-pressure
    for (int n = 0; n < 400; n++) begin
      if (n == 200) do_reset(CH'($urandom));
      for (int b = 0; b < CH*W; b++) m[b] = ($urandom_range(0, 5) == 0);
      ch_in = ch_in ^ m;
      if (n < 150) ifc.out_ready = ($urandom_range(0, 3) == 0);
      else         ifc.out_ready = ($urandom_range(0, 3) != 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/trace_change_monitor.md
# trace_change_monitor

Parametrised multi-channel value-change monitor that watches `CHANNELS` input buses of `WIDTH` bits and reports every detected change as an event record. Each record carries the channel index, new value and a sequence number, and is delivered through a bounded FIFO with a valid/ready handshake. The block sits beside simulated logic in regression benches, where replicated sub-cells each expose one signal bus. It generalises the per-instance "print on change" behaviour into a single ordered, back-pressured event stream with loss accounting.

## Interface
- `CHANNELS`, 10: number of monitored channels, 1..64.
- `WIDTH`, 1: bits per channel, 1..32.
- `DEPTH`, 4: event FIFO entries, power of two, at least 2.
- `CNTW`, 8: width of the sequence and coalesce counters.
- `CIW`, derived: max(1, $clog2(CHANNELS)); not overridable.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `ch_in`  in  CHANNELS*WIDTH  channel c occupies bits [c*WIDTH +: WIDTH].
- `out_valid`  out  1  FIFO head holds an event.
- `out_ready`  in  1  consumer accepts the head this cycle.
- `out_chan`  out  CIW  channel index of the head event.
- `out_value`  out  WIDTH  new value of the head event.
- `out_seq`  out  CNTW  sequence number of the head event.
- `coalesce_count`  out  CNTW  saturating count of overwritten pending changes.
- `busy`  out  1  high when `out_valid` is high or any pending flag is set.

## Operation
- **States:** INIT and RUN.
  - Reset enters INIT.
  - The first rising edge after reset release loads `prev[c]` from `ch_in` for all channels, generates no events, and moves to RUN.
  - RUN is held until the next reset.
- **Detect (RUN, every edge):** for each channel, if `ch_in[c] != prev[c]`, set `pend[c]=1` and `pval[c]=ch_in[c]`. `prev[c]` always takes `ch_in[c]`.
- **Coalesce:** a change arrives on a channel whose `pend` is already set and that channel is not granted in the same cycle.
  - `pval` is overwritten with the newest value.
  - `coalesce_count` increments, saturating at 2^CNTW-1.
- **Arbiter:**
  - Grants when the FIFO is not full (judged on the registered count; a same-cycle pop does not free a slot) and any `pend` is set.
  - Selects one channel round-robin, starting at `rr_ptr`.
  - Pushes {c, `pval[c]`, `seq`}, clears `pend[c]`, and sets `rr_ptr=c+1`, wrapping to 0 past `CHANNELS-1`.
  - `seq` increments modulo 2^CNTW on every push.
- **Grant with same-cycle change:** the old `pval` is pushed; `pend[c]` stays set with the new value; no coalesce is counted.
- **FIFO:**
  - `DEPTH` entries, in-order.
  - A pop happens when `out_valid && out_ready`.
  - Simultaneous push and pop is allowed whenever not full.
  - `out_*` show the head entry, driven from registers or a RAM read that is stable while `out_valid` is high and `out_ready` is low.
- **Backpressure:** when the FIFO is full, pending flags hold and further changes coalesce. Changes are never lost silently: every lost intermediate value is counted.
- **Reset mid-operation:** clears FIFO, pending flags, `seq`, `rr_ptr` and `coalesce_count`, and returns to INIT. In-flight events are discarded.

## Timing
- **Reset values:** `out_valid=0`, `out_chan=0`, `out_value=0`, `out_seq=0`, `coalesce_count=0`, `busy=0`; state INIT, `rr_ptr=0`, `seq=0`.
- **Minimum latency:**
  - Change sampled at edge t sets `pend` after t.
  - Push at edge t+1.
  - `out_valid` high after t+1.
- **Throughput:** one push and one pop per cycle. With K channels changing at edge t and the FIFO empty with `out_ready=1`, events occupy cycles t+1..t+K, in round-robin order from `rr_ptr`.
- **Handshake:** `out_valid` does not drop, and `out_*` do not change, until a pop.
- **Counter wrap:** `out_seq` 2^CNTW-1 is followed by 0. `coalesce_count` sticks at its maximum.

## Test plan
- **Startup suppression:** reset, then `ch_in` nonzero (all ones) at release. Required: no event after the INIT edge; `busy=0`.
- **Single change:** channel 3 toggles 0->1 at edge t with `out_ready=1`. Required: `out_valid` after t+1 with `out_chan=3`, `out_value=1`, `out_seq=0`; popped, then `busy=0`.
- **Simultaneous change:** all 10 channels change at one edge, `rr_ptr=0`, `DEPTH=4`, `out_ready=1`. Required: 10 events, channels 0..9, `seq` 0..9, no gaps, `coalesce_count=0`.
- **Backpressure and coalesce:** `out_ready=0`, `DEPTH=4`. Channels 0..4 change, then channel 4 changes twice more. Required: FIFO holds channels 0..3; channel 4 stays pending with its latest value; `coalesce_count=2`. On release, channel 4 is delivered with the final value and `seq=4`.
- **Grant/change race:** channel 2 is pending and granted in the same cycle it changes again. Required: two events for channel 2 with consecutive seq values, old value then new value, `coalesce_count` unchanged.
- **Reset mid-stream:** assert `rst_n` low with 3 events queued. Required: `out_valid=0` immediately (asynchronous); after release, the INIT edge produces no events and `seq` restarts at 0.
